regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 32x32 scalar register file among NREQ writeback

---
 rtl/wbarb_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wbarb_pkg.sv
// Shared constants and index helpers for the register-file writeback arbiter.
package wbarb_pkg;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NREGS    = 2 ** AW;
    localparam int NREQ_DEF = 3;
    localparam int MAXREQ   = 8;
    localparam int IDX_W    = 3;

    // Wrap a requester index that may have run one lap past n back into 0..n-1.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Writeback request arbiter: one-hot grant plus index. Round-robin from an internal
// pointer when WBARB_RR_EN is defined, otherwise fixed priority (lowest index wins).
module rr_arbiter
    import wbarb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
`ifdef WBARB_RR_EN
    input  logic             clk,
    input  logic             reset,
`endif
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int cand;

`ifdef WBARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = IDX_W'(wrap_idx(int'(gnt_idx) + 1, NREQ));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Scan candidates in priority order; first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef WBARB_RR_EN
            cand = wrap_idx(int'(rr_ptr_q) + k, NREQ);
`else
            cand = k;
`endif
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and tracks pending
// writes for RAW/WAW stalls. Build option WBARB_RR_EN selects round-robin arbitration.
module regfile_wb_arbiter #(
    parameter int NREQ = wbarb_pkg::NREQ_DEF,
    parameter int DW   = wbarb_pkg::DW,
    parameter int AW   = wbarb_pkg::AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_wn,
    input  logic [NREQ*DW-1:0] req_wd,
    output logic [NREQ-1:0]    req_ready,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_wn,
    output logic               iss_ready,
    input  logic [AW-1:0]      RN1,
    input  logic [AW-1:0]      RN2,
    output logic               busy1,
    output logic               busy2,
    output logic               RegWrite,
    output logic [AW-1:0]      WN,
    output logic [DW-1:0]      WD
);

    import wbarb_pkg::*;

    localparam int NR = 1 << AW;

    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             grant_fire;
    logic             issue_fire;
    logic [AW-1:0]    sel_wn;
    logic [DW-1:0]    sel_wd;

    logic [NR-1:0]    pending_q, pending_d;
    logic             regwrite_q, regwrite_d;
    logic [AW-1:0]    wn_q, wn_d;
    logic [DW-1:0]    wd_q, wd_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef WBARB_RR_EN
        .clk     (clk),
        .reset   (reset),
`endif
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Handshakes are held off while reset is asserted so nothing is accepted and lost.
    assign req_ready  = reset ? '0 : gnt;
    assign grant_fire = gnt_any && !reset;
    assign iss_ready  = !reset && !pending_q[iss_wn];
    assign issue_fire = iss_valid && iss_ready && (iss_wn != '0);
    assign busy1      = pending_q[RN1];
    assign busy2      = pending_q[RN2];

    assign sel_wn = req_wn[int'(gnt_idx)*AW +: AW];
    assign sel_wd = req_wd[int'(gnt_idx)*DW +: DW];

    always_comb begin
        regwrite_d = grant_fire && (sel_wn != '0);
        wn_d       = wn_q;
        wd_d       = wd_q;
        pending_d  = pending_q;
        if (grant_fire) begin
            wn_d              = sel_wn;
            wd_d              = sel_wd;
            pending_d[sel_wn] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[iss_wn] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            wn_q       <= '0;
            wd_q       <= '0;
            pending_q  <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wn_q       <= wn_d;
            wd_q       <= wd_d;
            pending_q  <= pending_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign WN       = wn_q;
    assign WD       = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_wn;
    logic [95:0] req_wd;
    logic [2:0]  req_ready;
    logic        iss_valid;
    logic [4:0]  iss_wn;
    logic        iss_ready;
    logic [4:0]  RN1, RN2;
    logic        busy1, busy2;
    logic        RegWrite;
    logic [4:0]  WN;
    logic [31:0] WD;

    int errors = 0;
    int checks = 0;
    int exp_g;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wn    (req_wn),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_wn    (iss_wn),
        .iss_ready (iss_ready),
        .RN1       (RN1),
        .RN2       (RN2),
        .busy1     (busy1),
        .busy2     (busy2),
        .RegWrite  (RegWrite),
        .WN        (WN),
        .WD        (WD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] wn, input logic [31:0] wd);
        req_valid[i]       = v;
        req_wn[i*5 +: 5]   = wn;
        req_wd[i*32 +: 32] = wd;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wn    = '0;
        req_wd    = '0;
        iss_valid = 1'b0;
        iss_wn    = '0;
        RN1       = '0;
        RN2       = '0;
        tick();
        tick();
        set_req(0, 1'b1, 5'd1, 32'h11);
        iss_valid = 1'b1;
        iss_wn    = 5'd4;
        #1;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wn", WN, 0);
        chk("rst_wd", WD, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        set_req(0, 1'b0, 5'd0, 32'h0);
        iss_valid = 1'b0;
        reset     = 1'b0;

        // reset mid-grant
        tick();
        iss_valid = 1'b1;
        iss_wn    = 5'd5;
        #1;
        chk("mid_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        RN1       = 5'd5;
        #1;
        chk("mid_busy_set", busy1, 1);
        set_req(0, 1'b1, 5'd5, 32'h55);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("mid_rst_regwrite", RegWrite, 0);
        chk("mid_rst_busy", busy1, 0);

        // single write
        iss_valid = 1'b1;
        iss_wn    = 5'd7;
        RN1       = 5'd7;
        #1;
        chk("sw_iss_ready", iss_ready, 1);
        chk("sw_busy_pre", busy1, 0);
        tick();
        iss_valid = 1'b0;
        set_req(1, 1'b1, 5'd7, 32'hDEAD);
        #1;
        chk("sw_ready", req_ready, 3'b010);
        chk("sw_busy_hold", busy1, 1);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("sw_regwrite", RegWrite, 1);
        chk("sw_wn", WN, 7);
        chk("sw_wd", WD, 32'hDEAD);
        chk("sw_busy_clr", busy1, 0);
        tick();
        chk("sw_pulse_end", RegWrite, 0);

        // contention, starting from a fresh pointer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 5'd10, 32'hA0);
        set_req(1, 1'b1, 5'd11, 32'hA1);
        set_req(2, 1'b1, 5'd12, 32'hA2);
        for (int k = 0; k < 3; k++) begin
`ifdef WBARB_RR_EN
            exp_g = k;
`else
            exp_g = 0;
`endif
            #1;
            chk("cont_ready", req_ready, 3'b001 << exp_g);
            tick();
            chk("cont_regwrite", RegWrite, 1);
            chk("cont_wn", WN, 10 + exp_g);
            chk("cont_wd", WD, 32'hA0 + exp_g);
        end
        req_valid = '0;
        tick();
        chk("idle_regwrite", RegWrite, 0);

        // WAW stall
        iss_valid = 1'b1;
        iss_wn    = 5'd3;
        RN2       = 5'd3;
        #1;
        chk("waw_first_ready", iss_ready, 1);
        tick();
        set_req(0, 1'b1, 5'd3, 32'h33);
        #1;
        chk("waw_stall", iss_ready, 0);
        chk("waw_busy", busy2, 1);
        chk("waw_grant", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("waw_release", iss_ready, 1);
        chk("waw_regwrite", RegWrite, 1);
        chk("waw_wn", WN, 3);
        chk("waw_busy_clr", busy2, 0);
        iss_valid = 1'b0;

        // r0 handling: r9 pending must survive an issue to r0
        iss_valid = 1'b1;
        iss_wn    = 5'd9;
        RN2       = 5'd9;
        tick();
        iss_wn = 5'd0;
        RN1    = 5'd0;
        #1;
        chk("r0_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("r0_busy", busy1, 0);
        chk("r0_other_pending", busy2, 1);
        set_req(2, 1'b1, 5'd0, 32'h99);
        #1;
        chk("r0_ready", req_ready, 3'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("r0_nowrite", RegWrite, 0);

        // back-to-back from requester 2
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b1, 5'(20 + k), 32'hB0 + k);
            #1;
            chk("b2b_ready", req_ready, 3'b100);
            tick();
            chk("b2b_regwrite", RegWrite, 1);
            chk("b2b_wn", WN, 20 + k);
            chk("b2b_wd", WD, 32'hB0 + k);
        end
        set_req(2, 1'b0, 5'd0, 32'h0);
        tick();
        chk("b2b_end", RegWrite, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
